// File: rtl/reg_op_pkg.sv
// Shared encodings and defaults for the register operation scheduler.
// The control codes describe the 4-bit shift/parity register being shared.
package reg_op_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_CNT_W  = 3;

  localparam logic [2:0] CTRL_HOLD = 3'b000;
  localparam logic [2:0] CTRL_LOAD = 3'b001;
  localparam logic [2:0] CTRL_SHL  = 3'b010;  // shift left, data_in[0] enters at bit 0
  localparam logic [2:0] CTRL_SHR  = 3'b011;  // shift right, data_in[MSB] enters at the top
  localparam logic [2:0] CTRL_ROL  = 3'b100;
  localparam logic [2:0] CTRL_ROR  = 3'b101;
  localparam logic [2:0] CTRL_PAR  = 3'b110;  // shift left with parity of contents as feedback
  localparam logic [2:0] CTRL_XOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester,
// pointer moves only when the owner signals an accepted grant via advance.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // last+1+k never exceeds 2*NREQ-1, so one wrap subtraction is enough
      cand = {1'b0, last_q} + (IDX_W+1)'(k + 1);
      if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
      idx = cand[IDX_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Reset value NREQ-1 makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(NREQ - 1);
    end else if (advance && found) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/reg_op_scheduler.sv
// Shares one control-driven shift/parity register between NREQ requesters:
// grants round-robin, drives op/data for count+1 cycles, returns the result.
module reg_op_scheduler
  import reg_op_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int NREQ   = 2,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                   rst_n,
  input  logic                   clk,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*CTRL_W-1:0] req_control,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [NREQ*CNT_W-1:0]  req_count,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [CTRL_W-1:0]      reg_control,
  output logic [WIDTH-1:0]       reg_data_in,
  input  logic [WIDTH-1:0]       reg_data_out,
  output state_t                 dbg_state
);

  localparam logic [CTRL_W-1:0] HOLD = CTRL_W'(CTRL_HOLD);

  // Handshake: a request transfers on a cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready is only ever set in IDLE, for the
  // round-robin winner. Responses are single-cycle pulses with no backpressure.

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [WIDTH-1:0]  din_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_d;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic              advance;

  logic [CTRL_W-1:0] ctl_a [NREQ];
  logic [WIDTH-1:0]  dat_a [NREQ];
  logic [CNT_W-1:0]  cnt_a [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ctl_a[i] = req_control[i*CTRL_W +: CTRL_W];
      dat_a[i] = req_data[i*WIDTH +: WIDTH];
      cnt_a[i] = req_count[i*CNT_W +: CNT_W];
    end
  end

  assign advance   = (state_q == IDLE) && (|req_valid);
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign dbg_state = state_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = reg_control;
    din_d       = reg_data_in;
    rem_d       = rem_q;
    id_d        = id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    case (state_q)
      IDLE: begin
        if (advance) begin
          ctrl_d  = ctl_a[grant_idx];
          din_d   = dat_a[grant_idx];
          rem_d   = cnt_a[grant_idx];
          id_d    = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          ctrl_d  = HOLD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Register has taken its last step; data_out is final here.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = reg_data_out;
        state_d     = IDLE;
      end
      default: begin
        ctrl_d  = HOLD;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_control <= HOLD;
      reg_data_in <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      state_q     <= state_d;
      reg_control <= ctrl_d;
      reg_data_in <= din_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      rsp_valid   <= rsp_valid_d;
      rsp_id      <= rsp_id_d;
      rsp_data    <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_reg_op_scheduler.sv
// Bench for reg_op_scheduler: attached register model, transaction-level
// scoreboard checked every cycle, and directed scenarios with literal results.
module tb_reg_op_scheduler;
  import reg_op_pkg::*;

  localparam int WIDTH  = 4;
  localparam int CTRL_W = 3;
  localparam int NREQ   = 2;
  localparam int CNT_W  = 3;
  localparam int ID_W   = 1;
  localparam int RSP_W  = ID_W + WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*CTRL_W-1:0] req_control;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ*CNT_W-1:0]  req_count;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic [CTRL_W-1:0]      reg_control;
  logic [WIDTH-1:0]       reg_data_in;
  logic [WIDTH-1:0]       reg_data_out;
  state_t                 dbg_state;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_op_scheduler #(
    .WIDTH(WIDTH), .CTRL_W(CTRL_W), .NREQ(NREQ), .CNT_W(CNT_W)
  ) dut (
    .rst_n(rst_n), .clk(clk),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_control(req_control), .req_data(req_data), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .reg_control(reg_control), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .dbg_state(dbg_state)
  );

  // ---------------- shared register (environment) ----------------
  function automatic logic [WIDTH-1:0] reg_step(input logic [WIDTH-1:0] q,
                                                input logic [CTRL_W-1:0] op,
                                                input logic [WIDTH-1:0] d);
    case (op)
      CTRL_HOLD: return q;
      CTRL_LOAD: return d;
      CTRL_SHL:  return {q[2:0], d[0]};
      CTRL_SHR:  return {d[3], q[3:1]};
      CTRL_ROL:  return {q[2:0], q[3]};
      CTRL_ROR:  return {q[0], q[3:1]};
      CTRL_PAR:  return {q[2:0], ^q};
      default:   return q ^ d;
    endcase
  endfunction

  logic [WIDTH-1:0] reg_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_step(reg_q, reg_control, reg_data_in);
  end
  assign reg_data_out = reg_q;

  // ---------------- model helpers ----------------
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] q,
                                                input logic [CTRL_W-1:0] op,
                                                input logic [WIDTH-1:0] d,
                                                input int n);
    logic [WIDTH-1:0] r;
    r = q;
    for (int s = 0; s < n; s++) r = reg_step(r, op, d);
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [RSP_W-1:0]  exp_q[$];
  int unsigned       due_q[$];
  bit                act;
  int unsigned       act_g, act_c;
  logic [CTRL_W-1:0] act_op, exp_ctrl;
  logic [WIDTH-1:0]  act_d, shadow;
  logic [NREQ-1:0]   exp_ready;
  int                last_g, hs_w;
  bit                busy, in_win, rsp_due;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      act    = 1'b0;
      last_g = NREQ - 1;
      shadow = '0;
    end else begin
      busy   = act && (cyc <= act_g + 2 + act_c);
      in_win = act && (cyc >= act_g + 1) && (cyc <= act_g + 1 + act_c);
      exp_ready = '0;
      hs_w = -1;
      if (!busy) begin
        hs_w = rr_pick(req_valid, last_g);
        if (hs_w >= 0) exp_ready = NREQ'(1) << hs_w;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'(1));
      exp_ctrl = in_win ? act_op : CTRL_HOLD;
      check("reg_control", 32'(reg_control), 32'(exp_ctrl));
      if (in_win) check("reg_data_in", 32'(reg_data_in), 32'(act_d));
      rsp_due = (due_q.size() > 0) && (due_q[0] == cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
      if (rsp_due) begin
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0][WIDTH +: ID_W]));
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0][WIDTH-1:0]));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (hs_w >= 0) begin
        act    = 1'b1;
        act_g  = cyc;
        act_op = req_control[hs_w*CTRL_W +: CTRL_W];
        act_d  = req_data[hs_w*WIDTH +: WIDTH];
        act_c  = int'(req_count[hs_w*CNT_W +: CNT_W]);
        shadow = apply_op(shadow, act_op, act_d, int'(act_c) + 1);
        exp_q.push_back({ID_W'(hs_w), shadow});
        due_q.push_back(cyc + 3 + act_c);
        last_g = hs_w;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [CTRL_W-1:0] op,
                         input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    req_control[i*CTRL_W +: CTRL_W] = op;
    req_data[i*WIDTH +: WIDTH]      = d;
    req_count[i*CNT_W +: CNT_W]     = c;
    req_valid[i]                    = 1'b1;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge of the handshake cycle.
  task automatic wait_grant(input logic [NREQ-1:0] mask, output int w, output int unsigned t);
    w = -1;
    t = 0;
    for (int k = 0; k < 40 && w < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i] && req_valid[i] && req_ready[i]) begin
          w = i;
          t = cyc;
        end
      end
    end
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL grant_timeout: no grant for mask %b within 40 cycles", mask);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int w, ng, nr, co, n;
    int unsigned t0, t1, rc;
    int gid[4];
    logic [WIDTH-1:0] rd[4];
    logic [NREQ-1:0] v;

    req_valid = '0; req_control = '0; req_data = '0; req_count = '0;
    check("model_rol2", 32'(apply_op(4'h9, CTRL_ROL, 4'h0, 2)), 32'h6);
    check("model_shr3", 32'(apply_op(4'h3, CTRL_SHR, 4'h8, 3)), 32'hE);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_reg_control", 32'(reg_control), 32'h0);
    check("rst_reg_data_in", 32'(reg_data_in), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset in the middle of a long ISSUE
    @(posedge clk); #1 set_req(0, CTRL_LOAD, 4'h7, 3'd5);
    wait_grant(2'b01, w, t0);
    @(posedge clk); #1 clr_req(0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_reg_control", 32'(reg_control), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("postrst_ready", 32'(req_ready), 32'h0);
      check("postrst_ctrl", 32'(reg_control), 32'h0);
      check("postrst_rsp", 32'(rsp_valid), 32'h0);
    end

    // Single LOAD, count 0
    @(posedge clk); #1 set_req(0, CTRL_LOAD, 4'hA, 3'd0);
    wait_grant(2'b01, w, t0);
    @(posedge clk); #1 clr_req(0);
    @(negedge clk);
    check("load_ctrl_t1", 32'(reg_control), 32'(CTRL_LOAD));
    check("load_din_t1", 32'(reg_data_in), 32'hA);
    @(negedge clk);
    check("load_ctrl_t2", 32'(reg_control), 32'(CTRL_HOLD));
    check("load_rsp_t2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("load_rsp_t3", 32'(rsp_valid), 32'h1);
    check("load_id_t3", 32'(rsp_id), 32'h0);
    check("load_data_t3", 32'(rsp_data), 32'hA);

    // Repeat count 3 from requester 1
    @(posedge clk); #1 set_req(1, CTRL_LOAD, 4'h5, 3'd3);
    wait_grant(2'b10, w, t0);
    @(posedge clk); #1 clr_req(1);
    n = 0; rc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_control == CTRL_LOAD) n++;
      if (rsp_valid) begin
        rc = cyc - t0;
        check("rep_id", 32'(rsp_id), 32'h1);
        check("rep_data", 32'(rsp_data), 32'h5);
      end
    end
    check("rep_load_cycles", 32'(n), 32'd4);
    check("rep_rsp_latency", rc, 32'd6);

    // Contention: both requesters continuously valid
    @(posedge clk); #1;
    set_req(0, CTRL_LOAD, 4'h3, 3'd0);
    set_req(1, CTRL_LOAD, 4'hC, 3'd0);
    ng = 0; nr = 0; co = 0;
    for (int k = 0; k < 40 && nr < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rd[nr] = rsp_data;
        nr++;
        if (|(req_valid & req_ready)) co++;
      end
      if (ng < 4) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            gid[ng] = i;
            ng++;
          end
        end
      end
    end
    @(posedge clk); #1 clr_req(0); clr_req(1);
    check("cont_grants", 32'(ng), 32'd4);
    check("cont_rsps", 32'(nr), 32'd4);
    check("cont_g0", 32'(gid[0]), 32'd0);
    check("cont_g1", 32'(gid[1]), 32'd1);
    check("cont_g2", 32'(gid[2]), 32'd0);
    check("cont_g3", 32'(gid[3]), 32'd1);
    check("cont_d0", 32'(rd[0]), 32'h3);
    check("cont_d1", 32'(rd[1]), 32'hC);
    check("cont_d2", 32'(rd[2]), 32'h3);
    check("cont_d3", 32'(rd[3]), 32'hC);
    check("cont_coincide", 32'(co), 32'd4);
    repeat (6) @(negedge clk);

    // Requester 1 arrives while requester 0 is busy
    @(posedge clk); #1 set_req(0, CTRL_LOAD, 4'h9, 3'd4);
    wait_grant(2'b01, w, t0);
    @(posedge clk); #1 clr_req(0); set_req(1, CTRL_ROL, 4'h0, 3'd1);
    wait_grant(2'b10, w, t1);
    check("busy_grant_delay", t1 - t0, 32'd7);
    @(posedge clk); #1 clr_req(1);
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        nr++;
        check("busy_rsp_id", 32'(rsp_id), 32'h1);
        check("busy_rsp_data", 32'(rsp_data), 32'h6);
      end
    end
    check("busy_rsp_count", 32'(nr), 32'd1);

    // Random regression
    for (int op = 0; op < 100; op++) begin
      @(posedge clk); #1;
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, CTRL_W'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 15)),
                CNT_W'($urandom_range(0, 7)));
      end
      req_valid = v;
      wait_grant(v, w, t0);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (14) @(negedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
